// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an optional 32-step iterative MUL/DIVU/REMU unit.
// Define EXECUTE_MULDIV_EN to build the multiply/divide FSM; otherwise aluop 8-10 are reserved.
module execute_stage #(
   parameter int MD_STEPS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_ex_valid,
   input  logic [3:0]  id_ex_aluop,
   input  logic [31:0] id_ex_rega,
   input  logic [31:0] id_ex_regb,
   input  logic [31:0] id_ex_imm,
   input  logic        id_ex_selimregb,
   input  logic        id_ex_readmem,
   input  logic        id_ex_writemem,
   input  logic        id_ex_selwsource,
   input  logic        id_ex_writereg,
   input  logic [4:0]  id_ex_regdest,
   output logic        ex_stall,
   output logic        ex_mem_readmem,
   output logic        ex_mem_writemem,
   output logic        ex_mem_selwsource,
   output logic        ex_mem_writereg,
   output logic [4:0]  ex_mem_regdest,
   output logic [31:0] ex_mem_regb,
   output logic [31:0] ex_mem_wbvalue
);
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8, OP_DIVU = 4'd9, OP_REMU = 4'd10;

   if (MD_STEPS != 32) begin : g_bad_steps
      $error("execute_stage: MD_STEPS must equal the 32-bit data width");
   end

   logic        [31:0] opb;
   logic signed [31:0] a_s, b_s;
   logic        [31:0] alu_res;
   logic               alu_ok;
   logic               issue_alu;

   assign opb       = id_ex_selimregb ? id_ex_imm : id_ex_regb;
   assign a_s       = id_ex_rega;
   assign b_s       = opb;
   assign issue_alu = id_ex_valid && alu_ok;

   always_comb begin
      alu_ok  = 1'b1;
      alu_res = '0;
      case (id_ex_aluop)
         OP_ADD:  alu_res = id_ex_rega + opb;
         OP_SUB:  alu_res = id_ex_rega - opb;
         OP_AND:  alu_res = id_ex_rega & opb;
         OP_OR:   alu_res = id_ex_rega | opb;
         OP_XOR:  alu_res = id_ex_rega ^ opb;
         OP_SLT:  alu_res = {31'b0, (a_s < b_s)};
         OP_SLL:  alu_res = id_ex_rega << opb[4:0];
         OP_SRL:  alu_res = id_ex_rega >> opb[4:0];
         default: alu_ok  = 1'b0;
      endcase
   end

   logic        nxt_readmem, nxt_writemem, nxt_selwsource, nxt_writereg;
   logic [4:0]  nxt_regdest;
   logic [31:0] nxt_regb, nxt_wbvalue;

`ifdef EXECUTE_MULDIV_EN
   localparam int CNT_W = $clog2(MD_STEPS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   md_state_t        state;
   logic [CNT_W-1:0] count;
   logic [3:0]       op_p1;
   logic             readmem_p1, writemem_p1, selwsource_p1, writereg_p1;
   logic [4:0]       regdest_p1;
   logic [31:0]      regb_p1;
   logic [31:0]      acc_p1, x_p1, y_p1;
   logic             md_req;
   logic [31:0]      md_result;

   // One restoring-division step: returns {remainder, quotient}. A zero divisor
   // always "fits", which yields quotient all-ones and remainder equal to the dividend.
   function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                            input logic [31:0] dvs);
      logic [32:0] rem_sh, diff;
      rem_sh = {rem, quo[31]};
      diff   = rem_sh - {1'b0, dvs};
      if (rem_sh >= {1'b0, dvs}) return {diff[31:0], quo[30:0], 1'b1};
      else                       return {rem_sh[31:0], quo[30:0], 1'b0};
   endfunction

   assign md_req    = id_ex_valid &&
                      (id_ex_aluop == OP_MUL || id_ex_aluop == OP_DIVU || id_ex_aluop == OP_REMU);
   assign ex_stall  = reset && ((state == IDLE && md_req) || state == BUSY);
   assign md_result = (op_p1 == OP_DIVU) ? x_p1 : acc_p1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         count         <= '0;
         op_p1         <= '0;
         readmem_p1    <= 1'b0;
         writemem_p1   <= 1'b0;
         selwsource_p1 <= 1'b0;
         writereg_p1   <= 1'b0;
         regdest_p1    <= '0;
      end else begin
         case (state)
            IDLE: if (md_req) begin
               state         <= BUSY;
               count         <= CNT_W'(MD_STEPS - 1);
               op_p1         <= id_ex_aluop;
               readmem_p1    <= id_ex_readmem;
               writemem_p1   <= id_ex_writemem;
               selwsource_p1 <= id_ex_selwsource;
               writereg_p1   <= id_ex_writereg;
               regdest_p1    <= id_ex_regdest;
            end
            BUSY: begin
               if (count == '0) state <= DONE;
               else             count <= count - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p1: iterative datapath, MUL keeps {acc, mcand, mplier}, DIV keeps {rem, quo, divisor}
   always_ff @(posedge clock) begin
      if (state == IDLE && md_req) begin
         acc_p1  <= '0;
         x_p1    <= id_ex_rega;
         y_p1    <= opb;
         regb_p1 <= id_ex_regb;
      end else if (state == BUSY) begin
         if (op_p1 == OP_MUL) begin
            acc_p1 <= acc_p1 + (y_p1[0] ? x_p1 : 32'd0);
            x_p1   <= x_p1 << 1;
            y_p1   <= y_p1 >> 1;
         end else begin
            {acc_p1, x_p1} <= div_step(acc_p1, x_p1, y_p1);
         end
      end
   end

   always_comb begin
      nxt_readmem    = 1'b0;
      nxt_writemem   = 1'b0;
      nxt_selwsource = 1'b0;
      nxt_writereg   = 1'b0;
      nxt_regdest    = '0;
      nxt_regb       = '0;
      nxt_wbvalue    = '0;
      if (state == DONE) begin
         nxt_readmem    = readmem_p1;
         nxt_writemem   = writemem_p1;
         nxt_selwsource = selwsource_p1;
         nxt_writereg   = writereg_p1;
         nxt_regdest    = regdest_p1;
         nxt_regb       = regb_p1;
         nxt_wbvalue    = md_result;
      end else if (state == IDLE && issue_alu) begin
         nxt_readmem    = id_ex_readmem;
         nxt_writemem   = id_ex_writemem;
         nxt_selwsource = id_ex_selwsource;
         nxt_writereg   = id_ex_writereg;
         nxt_regdest    = id_ex_regdest;
         nxt_regb       = id_ex_regb;
         nxt_wbvalue    = alu_res;
      end
   end
`else
   assign ex_stall = 1'b0;

   always_comb begin
      nxt_readmem    = 1'b0;
      nxt_writemem   = 1'b0;
      nxt_selwsource = 1'b0;
      nxt_writereg   = 1'b0;
      nxt_regdest    = '0;
      nxt_regb       = '0;
      nxt_wbvalue    = '0;
      if (issue_alu) begin
         nxt_readmem    = id_ex_readmem;
         nxt_writemem   = id_ex_writemem;
         nxt_selwsource = id_ex_selwsource;
         nxt_writereg   = id_ex_writereg;
         nxt_regdest    = id_ex_regdest;
         nxt_regb       = id_ex_regb;
         nxt_wbvalue    = alu_res;
      end
   end
`endif

   // EX/MEM register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_mem_readmem    <= 1'b0;
         ex_mem_writemem   <= 1'b0;
         ex_mem_selwsource <= 1'b0;
         ex_mem_writereg   <= 1'b0;
         ex_mem_regdest    <= '0;
         ex_mem_regb       <= '0;
         ex_mem_wbvalue    <= '0;
      end else begin
         ex_mem_readmem    <= nxt_readmem;
         ex_mem_writemem   <= nxt_writemem;
         ex_mem_selwsource <= nxt_selwsource;
         ex_mem_writereg   <= nxt_writereg;
         ex_mem_regdest    <= nxt_regdest;
         ex_mem_regb       <= nxt_regb;
         ex_mem_wbvalue    <= nxt_wbvalue;
      end
   end
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; muldiv expectations follow EXECUTE_MULDIV_EN.
module tb_execute_stage;
   logic        clock = 1'b0;
   logic        reset;
   logic        id_ex_valid;
   logic [3:0]  id_ex_aluop;
   logic [31:0] id_ex_rega, id_ex_regb, id_ex_imm;
   logic        id_ex_selimregb;
   logic        id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg;
   logic [4:0]  id_ex_regdest;
   logic        ex_stall;
   logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
   logic [4:0]  ex_mem_regdest;
   logic [31:0] ex_mem_regb, ex_mem_wbvalue;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   execute_stage dut (
      .clock(clock), .reset(reset),
      .id_ex_valid(id_ex_valid), .id_ex_aluop(id_ex_aluop),
      .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imm(id_ex_imm),
      .id_ex_selimregb(id_ex_selimregb),
      .id_ex_readmem(id_ex_readmem), .id_ex_writemem(id_ex_writemem),
      .id_ex_selwsource(id_ex_selwsource), .id_ex_writereg(id_ex_writereg),
      .id_ex_regdest(id_ex_regdest),
      .ex_stall(ex_stall),
      .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
      .ex_mem_selwsource(ex_mem_selwsource), .ex_mem_writereg(ex_mem_writereg),
      .ex_mem_regdest(ex_mem_regdest), .ex_mem_regb(ex_mem_regb),
      .ex_mem_wbvalue(ex_mem_wbvalue)
   );

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic sel,
                        input logic [4:0] rd);
      id_ex_valid      = v;
      id_ex_aluop      = op;
      id_ex_rega       = a;
      id_ex_regb       = b;
      id_ex_imm        = im;
      id_ex_selimregb  = sel;
      id_ex_regdest    = rd;
      id_ex_writereg   = v;
      id_ex_readmem    = 1'b0;
      id_ex_writemem   = 1'b0;
      id_ex_selwsource = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd3);
      step();
      total++; if (ex_mem_wbvalue !== 32'd0) begin bad++; $display("FAIL reset_wbvalue got=%h want=0", ex_mem_wbvalue); end
      total++; if (ex_mem_writereg !== 1'b0) begin bad++; $display("FAIL reset_writereg got=%b want=0", ex_mem_writereg); end
      total++; if (ex_mem_regdest !== 5'd0) begin bad++; $display("FAIL reset_regdest got=%0d want=0", ex_mem_regdest); end
      total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", ex_stall); end
      reset = 1'b1;
`ifdef EXECUTE_MULDIV_EN
      drive(1'b1, 4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 5'd4);
      repeat (10) step();
      total++; if (ex_stall !== 1'b1) begin bad++; $display("FAIL divu_busy_stall got=%b want=1", ex_stall); end
      reset = 1'b0;
      #1;
      total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b want=0", ex_stall); end
      total++; if (ex_mem_writereg !== 1'b0 || ex_mem_wbvalue !== 32'd0)
         begin bad++; $display("FAIL midreset_out got wr=%b wb=%h want 0/0", ex_mem_writereg, ex_mem_wbvalue); end
      drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      step();
      reset = 1'b1;
`endif
      drive(1'b1, 4'd0, 32'd5, 32'd3, 32'd0, 1'b0, 5'd7);
      step();
      total++; if (ex_mem_wbvalue !== 32'd8) begin bad++; $display("FAIL post_reset_add got=%0d want=8", ex_mem_wbvalue); end
      total++; if (ex_mem_writereg !== 1'b1 || ex_mem_regdest !== 5'd7)
         begin bad++; $display("FAIL post_reset_ctrl got wr=%b rd=%0d want 1/7", ex_mem_writereg, ex_mem_regdest); end
   endtask

   task automatic test_load();
      drive(1'b1, 4'd0, 32'h100, 32'hDEADBEEF, 32'h0C, 1'b1, 5'd5);
      id_ex_readmem    = 1'b1;
      id_ex_selwsource = 1'b1;
      step();
      total++; if (ex_mem_wbvalue !== 32'h10C) begin bad++; $display("FAIL load_addr got=%h want=10c", ex_mem_wbvalue); end
      total++; if (ex_mem_readmem !== 1'b1 || ex_mem_selwsource !== 1'b1 || ex_mem_writemem !== 1'b0)
         begin bad++; $display("FAIL load_ctrl got rm=%b ws=%b wm=%b want 1/1/0", ex_mem_readmem, ex_mem_selwsource, ex_mem_writemem); end
      total++; if (ex_mem_regb !== 32'hDEADBEEF) begin bad++; $display("FAIL load_regb got=%h want=deadbeef", ex_mem_regb); end
      total++; if (ex_mem_regdest !== 5'd5) begin bad++; $display("FAIL load_regdest got=%0d want=5", ex_mem_regdest); end
   endtask

   task automatic test_alu();
      logic [3:0]  ops  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0};
      logic [31:0] as   [9] = '{32'd10, 32'hF0F0, 32'hF000, 32'hFF, 32'hFFFFFFFF, 32'd1,
                                32'd1, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] bs   [9] = '{32'd3, 32'h0FF0, 32'h000F, 32'h0F, 32'd1, 32'hFFFFFFFF,
                                32'd4, 32'd0, 32'd1};
      logic [31:0] ims  [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd33, 32'd0};
      logic        sels [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] exps [9] = '{32'd7, 32'h00F0, 32'hF00F, 32'hF0, 32'd1, 32'd0,
                                32'h10, 32'h40000000, 32'd0};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, ops[i], as[i], bs[i], ims[i], sels[i], 5'(i + 1));
         #1;
         total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL alu%0d_stall got=%b want=0", i, ex_stall); end
         step();
         total++; if (ex_mem_wbvalue !== exps[i] || ex_mem_writereg !== 1'b1)
            begin bad++; $display("FAIL alu%0d op=%0d got=%h wr=%b want=%h wr=1", i, ops[i], ex_mem_wbvalue, ex_mem_writereg, exps[i]); end
      end
   endtask

   task automatic test_bubbles();
      drive(1'b1, 4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd9);
      step();
      drive(1'b1, 4'd12, 32'd9, 32'd9, 32'd0, 1'b0, 5'd9);
      #1;
      total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL reserved_stall got=%b want=0", ex_stall); end
      step();
      total++; if (ex_mem_writereg !== 1'b0 || ex_mem_wbvalue !== 32'd0 || ex_mem_regdest !== 5'd0)
         begin bad++; $display("FAIL reserved_bubble got wr=%b wb=%h rd=%0d want 0/0/0", ex_mem_writereg, ex_mem_wbvalue, ex_mem_regdest); end
      drive(1'b1, 4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd9);
      step();
      drive(1'b0, 4'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd9);
      id_ex_writereg = 1'b1;
      step();
      total++; if (ex_mem_writereg !== 1'b0 || ex_mem_wbvalue !== 32'd0 || ex_mem_regdest !== 5'd0)
         begin bad++; $display("FAIL invalid_bubble got wr=%b wb=%h rd=%0d want 0/0/0", ex_mem_writereg, ex_mem_wbvalue, ex_mem_regdest); end
   endtask

`ifdef EXECUTE_MULDIV_EN
   task automatic test_muldiv_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expv, input logic [4:0] rd, input string name);
      int stall_cnt;
      int bubble_err;
      bubble_err = 0;
      drive(1'b1, op, a, b, 32'd0, 1'b0, rd);
      #1;
      stall_cnt = int'(ex_stall);
      for (int n = 1; n <= 34; n++) begin
         step();
         if (n < 34) begin
            if (ex_mem_writereg !== 1'b0 || ex_mem_wbvalue !== 32'd0) bubble_err++;
            stall_cnt += int'(ex_stall === 1'b1);
            id_ex_rega = 32'h5A5A5A5A;
            id_ex_regb = 32'h3;
         end
      end
      drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      total++; if (bubble_err !== 0) begin bad++; $display("FAIL %s_early_output got=%0d nonbubble cycles want=0", name, bubble_err); end
      total++; if (stall_cnt !== 33) begin bad++; $display("FAIL %s_stall_cycles got=%0d want=33", name, stall_cnt); end
      total++; if (ex_mem_wbvalue !== expv) begin bad++; $display("FAIL %s_result got=%h want=%h", name, ex_mem_wbvalue, expv); end
      total++; if (ex_mem_writereg !== 1'b1 || ex_mem_regdest !== rd)
         begin bad++; $display("FAIL %s_ctrl got wr=%b rd=%0d want 1/%0d", name, ex_mem_writereg, ex_mem_regdest, rd); end
   endtask
`endif

   task automatic test_muldiv();
`ifdef EXECUTE_MULDIV_EN
      test_muldiv_op(4'd8,  32'd7,        32'd2 * 3, 32'd42,        5'd11, "mul");
      test_muldiv_op(4'd8,  32'hFFFFFFFF, 32'd2,     32'hFFFFFFFE,  5'd12, "mul_wrap");
      test_muldiv_op(4'd9,  32'd100,      32'd7,     32'd14,        5'd13, "divu");
      test_muldiv_op(4'd10, 32'd100,      32'd7,     32'd2,         5'd14, "remu");
      test_muldiv_op(4'd9,  32'd9,        32'd0,     32'hFFFFFFFF,  5'd15, "divu_zero");
      test_muldiv_op(4'd10, 32'd9,        32'd0,     32'd9,         5'd16, "remu_zero");
`else
      drive(1'b1, 4'd8, 32'd7, 32'd6, 32'd0, 1'b0, 5'd11);
      #1;
      total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL mul_off_stall got=%b want=0", ex_stall); end
      step();
      total++; if (ex_mem_writereg !== 1'b0 || ex_mem_wbvalue !== 32'd0)
         begin bad++; $display("FAIL mul_off_bubble got wr=%b wb=%h want 0/0", ex_mem_writereg, ex_mem_wbvalue); end
      drive(1'b1, 4'd10, 32'd9, 32'd0, 32'd0, 1'b0, 5'd12);
      step();
      total++; if (ex_mem_writereg !== 1'b0 || ex_mem_regdest !== 5'd0)
         begin bad++; $display("FAIL remu_off_bubble got wr=%b rd=%0d want 0/0", ex_mem_writereg, ex_mem_regdest); end
      drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
`endif
   endtask

   task automatic test_back_to_back();
`ifdef EXECUTE_MULDIV_EN
      test_muldiv_op(4'd8, 32'd7, 32'd6, 32'd42, 5'd20, "b2b_mul");
`else
      drive(1'b1, 4'd8, 32'd7, 32'd6, 32'd0, 1'b0, 5'd20);
      step();
      total++; if (ex_mem_writereg !== 1'b0) begin bad++; $display("FAIL b2b_mul_off got wr=%b want=0", ex_mem_writereg); end
`endif
      drive(1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd21);
      step();
      total++; if (ex_mem_wbvalue !== 32'd3 || ex_mem_regdest !== 5'd21 || ex_mem_writereg !== 1'b1)
         begin bad++; $display("FAIL b2b_add got wb=%h rd=%0d wr=%b want 3/21/1", ex_mem_wbvalue, ex_mem_regdest, ex_mem_writereg); end
      drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      step();
      total++; if (ex_mem_writereg !== 1'b0 || ex_stall !== 1'b0)
         begin bad++; $display("FAIL b2b_no_dup got wr=%b stall=%b want 0/0", ex_mem_writereg, ex_stall); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_alu();
      test_bubbles();
      test_muldiv();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
